// File: rtl/damage_resolver_if.sv
// Hit-scan / game-state bundle between the damage resolver and its surroundings.
// The master side drives frame timing, hit flags and FSM codes; the slave side returns game state.
interface damage_resolver_if #(
    parameter int HEALTH_W = 7
);
    logic                frame_tick;
    logic                hitscan1;
    logic                hitscan2;
    logic [3:0]          Player1NS;
    logic [3:0]          Player2NS;
    logic [HEALTH_W-1:0] p1_health;
    logic [HEALTH_W-1:0] p2_health;
    logic                p1_hit_pulse;
    logic                p2_hit_pulse;
    logic                p1_stunned;
    logic                p2_stunned;
    logic                p1_invuln;
    logic                p2_invuln;
    logic                game_over;
    logic [1:0]          winner;

    modport master (
        output frame_tick, hitscan1, hitscan2, Player1NS, Player2NS,
        input  p1_health, p2_health, p1_hit_pulse, p2_hit_pulse,
               p1_stunned, p2_stunned, p1_invuln, p2_invuln, game_over, winner
    );

    modport slave (
        input  frame_tick, hitscan1, hitscan2, Player1NS, Player2NS,
        output p1_health, p2_health, p1_hit_pulse, p2_hit_pulse,
               p1_stunned, p2_stunned, p1_invuln, p2_invuln, game_over, winner
    );
endinterface

// File: rtl/damage_resolver.sv
// Turns hit-scan flags into health, hit-stun / invulnerability windows and the game result.
// Index 0 is player 1, index 1 is player 2; each victim is damaged by the other player's state.
module damage_resolver #(
    parameter int HEALTH_W      = 7,
    parameter int MAX_HEALTH    = 100,
    parameter int BASIC_DMG     = 10,
    parameter int DIR_DMG       = 15,
    parameter int STUN_FRAMES   = 12,
    parameter int INVULN_FRAMES = 20
) (
    input  logic              clk,
    input  logic              rst,
    damage_resolver_if.slave  bus
);

    typedef logic [HEALTH_W-1:0] health_t;
    typedef enum logic [1:0] {READY, STUN, INVULN} state_t;

    localparam health_t    MAX_H     = health_t'(MAX_HEALTH);
    localparam health_t    BASIC_D   = health_t'(BASIC_DMG);
    localparam health_t    DIR_D     = health_t'(DIR_DMG);
    localparam logic [7:0] STUN_LD   = 8'(STUN_FRAMES);
    localparam logic [7:0] INVULN_LD = 8'(INVULN_FRAMES);

    state_t     r_state      [2];
    state_t     w_state_nxt  [2];
    logic [7:0] r_cnt        [2];
    logic [7:0] w_cnt_nxt    [2];
    health_t    r_health     [2];
    health_t    w_health_nxt [2];
    logic [3:0] w_att_ns     [2];
    logic [1:0] r_pulse;
    logic [1:0] w_accept;
    logic [1:0] w_scan;
    logic       w_game_over;

    function automatic health_t sat_sub(input health_t h, input health_t d);
        return (h > d) ? h - d : '0;
    endfunction

    function automatic health_t dmg_of(input logic [3:0] ns);
        return (ns == 4'd7) ? DIR_D : BASIC_D;
    endfunction

    function automatic logic is_attack(input logic [3:0] ns);
        return (ns == 4'd4) || (ns == 4'd7);
    endfunction

    assign w_scan      = {bus.hitscan2, bus.hitscan1};
    assign w_att_ns[0] = bus.Player2NS;
    assign w_att_ns[1] = bus.Player1NS;
    assign w_game_over = (r_health[0] == '0) || (r_health[1] == '0);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_state_nxt[i]  = r_state[i];
            w_cnt_nxt[i]    = r_cnt[i];
            w_health_nxt[i] = r_health[i];
            w_accept[i]     = 1'b0;
            case (r_state[i])
                READY: begin
                    // A tick on the accept edge is deliberately not counted.
                    if (w_scan[i] && !w_game_over && is_attack(w_att_ns[i])) begin
                        w_accept[i]     = 1'b1;
                        w_health_nxt[i] = sat_sub(r_health[i], dmg_of(w_att_ns[i]));
                        w_state_nxt[i]  = STUN;
                        w_cnt_nxt[i]    = STUN_LD;
                    end
                end
                STUN: begin
                    if (bus.frame_tick) begin
                        if (r_cnt[i] == 8'd1) begin
                            w_state_nxt[i] = INVULN;
                            w_cnt_nxt[i]   = INVULN_LD;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] - 8'd1;
                        end
                    end
                end
                INVULN: begin
                    if (bus.frame_tick) begin
                        if (r_cnt[i] == 8'd1) begin
                            w_state_nxt[i] = READY;
                            w_cnt_nxt[i]   = 8'd0;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] - 8'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt[i] = READY;
                    w_cnt_nxt[i]   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_state[i]  <= READY;
                r_cnt[i]    <= 8'd0;
                r_health[i] <= MAX_H;
            end
            r_pulse <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_state[i]  <= w_state_nxt[i];
                r_cnt[i]    <= w_cnt_nxt[i];
                r_health[i] <= w_health_nxt[i];
            end
            r_pulse <= w_accept;
        end
    end

    assign bus.p1_health    = r_health[0];
    assign bus.p2_health    = r_health[1];
    assign bus.p1_hit_pulse = r_pulse[0];
    assign bus.p2_hit_pulse = r_pulse[1];
    assign bus.p1_stunned   = (r_state[0] == STUN);
    assign bus.p2_stunned   = (r_state[1] == STUN);
    assign bus.p1_invuln    = (r_state[0] == INVULN);
    assign bus.p2_invuln    = (r_state[1] == INVULN);
    assign bus.game_over    = w_game_over;
    // Bit 1 flags P1 dead, bit 0 flags P2 dead: 01 P1 wins, 10 P2 wins, 11 draw.
    assign bus.winner       = {r_health[0] == '0, r_health[1] == '0};

endmodule
